// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline hazard controller bus: the fetched and decoded instructions and the
// restart request come in; the decode controls, pipeline enables, forwarding
// select and status go out.
//   master : pipeline side (drives instructions and Resume, observes controls)
//   slave  : hazard controller side
interface pipe_hazard_ctrl_if;
    logic [7:0] Instruction_Code;        // IF-stage fetched instruction
    logic [7:0] IF_ID_Instruction_Code;  // ID-stage instruction
    logic       Resume;                  // single-cycle restart request
    logic       RegWrite;                // decoded write control
    logic       SMCtrl;                  // decoded immediate-select control
    logic       PC_En;                   // PC advance enable
    logic       IF_ID_En;                // IF/ID load enable
    logic       Bubble;                  // inject NOP into ID/EX
    logic [1:0] Fwd_Src;                 // 00 regfile, 01 EX, 10 WB
    logic       Halted;                  // core halted
    logic [1:0] State;                   // FSM state
    logic [7:0] Stall_Count;             // saturating stall-cycle count

    modport master (
        output Instruction_Code, IF_ID_Instruction_Code, Resume,
        input  RegWrite, SMCtrl, PC_En, IF_ID_En, Bubble, Fwd_Src,
               Halted, State, Stall_Count
    );

    modport slave (
        input  Instruction_Code, IF_ID_Instruction_Code, Resume,
        output RegWrite, SMCtrl, PC_En, IF_ID_En, Bubble, Fwd_Src,
               Halted, State, Stall_Count
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard / halt controller for a small 3-stage-writer pipeline.
// Decodes the IF instruction, tracks in-flight writers in EX and WB, stalls
// (or forwards) on RAW hazards, and sequences HALT through DRAIN, HALTED and
// a one-cycle RESTART.
// Ports:
//   Clk    : rising-edge clock
//   Reset  : asynchronous active-low reset
//   bus    : pipe_hazard_ctrl_if.slave (instructions, Resume, controls, status)
// Build option: define FWD_EN to resolve RAW hazards by forwarding instead of
// stalling.
module pipe_hazard_ctrl (
    input  logic                Clk,
    input  logic                Reset,
    pipe_hazard_ctrl_if.slave   bus
);

    localparam int unsigned OP_W  = 2;
    localparam int unsigned REG_W = 3;
    localparam int unsigned CNT_W = 8;

    localparam logic [OP_W-1:0] OP_MOV  = 2'b00;
    localparam logic [OP_W-1:0] OP_SMOV = 2'b01;
    localparam logic [OP_W-1:0] OP_HALT = 2'b11;

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        DRAIN   = 2'b01,
        HALTED  = 2'b10,
        RESTART = 2'b11
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               ex_v;
    logic               wb_v;
    logic [REG_W-1:0]   ex_rd;
    logic [REG_W-1:0]   wb_rd;
    logic               halted;
    logic [CNT_W-1:0]   stall_count;

    logic [OP_W-1:0]    if_op;
    logic [OP_W-1:0]    id_op;
    logic [REG_W-1:0]   id_rd;
    logic [REG_W-1:0]   id_rs;
    logic               id_wr;
    logic               ex_match;
    logic               wb_match;
    logic               raw_stall;
    logic [1:0]         fwd_src;
    logic               pc_en;
    logic               if_id_en;
    logic               bubble;
    logic               stall;
    logic               unused_if_bits;

    // Instruction field extraction; only the IF opcode is needed for decode
    assign if_op          = bus.Instruction_Code[7:6];
    assign unused_if_bits = ^bus.Instruction_Code[5:0];
    assign id_op          = bus.IF_ID_Instruction_Code[7:6];
    assign id_rd          = bus.IF_ID_Instruction_Code[5:3];
    assign id_rs          = bus.IF_ID_Instruction_Code[2:0];
    assign id_wr          = (id_op == OP_MOV) || (id_op == OP_SMOV);

    // Only MOV reads a register, so SMOV/NOP/HALT never match
    assign ex_match = (id_op == OP_MOV) && ex_v && (ex_rd == id_rs);
    assign wb_match = (id_op == OP_MOV) && wb_v && (wb_rd == id_rs);

`ifdef FWD_EN
    // Forwarding: EX holds the youngest value, so it wins over WB
    assign raw_stall = 1'b0;
    always_comb begin
        fwd_src = 2'b00;
        if (ex_match) begin
            fwd_src = 2'b01;
        end else if (wb_match) begin
            fwd_src = 2'b10;
        end
    end
`else
    assign raw_stall = ex_match | wb_match;
    assign fwd_src   = 2'b00;
`endif

    // Next-state and pipeline-control logic
    always_comb begin
        state_next = state;
        pc_en      = 1'b1;
        if_id_en   = 1'b1;
        bubble     = 1'b0;
        stall      = 1'b0;
        unique case (state)
            RUN: begin
                if (id_op == OP_HALT) begin
                    state_next = DRAIN;
                    pc_en      = 1'b0;
                    if_id_en   = 1'b0;
                    bubble     = 1'b1;
                end else if (raw_stall) begin
                    stall      = 1'b1;
                    pc_en      = 1'b0;
                    if_id_en   = 1'b0;
                    bubble     = 1'b1;
                end
            end
            DRAIN: begin
                pc_en    = 1'b0;
                if_id_en = 1'b0;
                bubble   = 1'b1;
                if (!ex_v && !wb_v) begin
                    state_next = HALTED;
                end
            end
            HALTED: begin
                pc_en    = 1'b0;
                if_id_en = 1'b0;
                bubble   = 1'b1;
                if (bus.Resume) begin
                    state_next = RESTART;
                end
            end
            RESTART: begin
                // Fetch resumes while the held HALT in ID is squashed
                bubble     = 1'b1;
                state_next = RUN;
            end
        endcase
    end

    // While in reset the pipeline runs freely regardless of what sits in ID
    assign bus.PC_En       = Reset ? pc_en    : 1'b1;
    assign bus.IF_ID_En    = Reset ? if_id_en : 1'b1;
    assign bus.Bubble      = Reset & bubble;
    assign bus.RegWrite    = (state == RUN) && ((if_op == OP_MOV) || (if_op == OP_SMOV));
    assign bus.SMCtrl      = (state == RUN) && (if_op == OP_SMOV);
    assign bus.Fwd_Src     = fwd_src;
    assign bus.State       = state;
    assign bus.Halted      = halted;
    assign bus.Stall_Count = stall_count;

    // State, writer trackers, halt flag and saturating stall counter
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state       <= RUN;
            ex_v        <= 1'b0;
            ex_rd       <= '0;
            wb_v        <= 1'b0;
            wb_rd       <= '0;
            halted      <= 1'b0;
            stall_count <= '0;
        end else begin
            state  <= state_next;
            halted <= (state_next == HALTED);
            wb_v   <= ex_v;
            wb_rd  <= ex_rd;
            ex_v   <= id_wr & ~bubble;
            ex_rd  <= id_rd;
            if (stall && (stall_count != {CNT_W{1'b1}})) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: the stimulus process plays the
// pipeline, driving IF and ID instructions per cycle and queuing the
// hand-derived expected controls; the monitor compares them on the falling edge.
module tb_pipe_hazard_ctrl;

`ifdef FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // Expected controls on a RAW cycle: stall without forwarding, flow with it
    localparam logic       SP = FWD;
    localparam logic       SB = !FWD;
    localparam logic [1:0] F1 = FWD ? 2'b01 : 2'b00;
    localparam logic [1:0] F2 = FWD ? 2'b10 : 2'b00;

    typedef struct packed {
        logic [1:0] st;
        logic       h;
        logic       pc;
        logic       ie;
        logic       bub;
        logic [1:0] fw;
        logic       rw;
        logic       sm;
        logic [7:0] sc;
    } exp_t;

    logic Clk;
    logic Reset;
    pipe_hazard_ctrl_if bus ();

    pipe_hazard_ctrl dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    exp_t  exp_q[$];
    string nm_q[$];
    int    checks   = 0;
    int    failures = 0;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic exp_t mk(input logic [1:0] st, input logic h, input logic pc,
                                input logic ie, input logic bub, input logic [1:0] fw,
                                input logic rw, input logic sm, input logic [7:0] sc);
        exp_t e;
        e.st = st; e.h = h; e.pc = pc; e.ie = ie; e.bub = bub;
        e.fw = fw; e.rw = rw; e.sm = sm; e.sc = sc;
        return e;
    endfunction

    function automatic logic [7:0] s(input int n);
        return FWD ? 8'd0 : 8'(n);
    endfunction

    // One pipeline cycle: drive inputs just after the edge, optionally queue expectation
    task automatic step(input string nm, input logic [7:0] ifc, input logic [7:0] idc,
                        input logic res, input logic rst, input logic chk, input exp_t e);
        @(posedge Clk);
        #1;
        Reset                      = rst;
        bus.Instruction_Code       = ifc;
        bus.IF_ID_Instruction_Code = idc;
        bus.Resume                 = res;
        if (chk) begin
            exp_q.push_back(e);
            nm_q.push_back(nm);
        end
    endtask

    // Monitor: compare every queued expectation against the DUT mid-cycle
    initial begin
        exp_t  e;
        exp_t  a;
        string n;
        forever begin
            @(negedge Clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = nm_q.pop_front();
                a = mk(bus.State, bus.Halted, bus.PC_En, bus.IF_ID_En, bus.Bubble,
                       bus.Fwd_Src, bus.RegWrite, bus.SMCtrl, bus.Stall_Count);
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL %s: got st=%0d h=%b pc=%b ie=%b bub=%b fwd=%0d rw=%b sm=%b sc=%0d | expected st=%0d h=%b pc=%b ie=%b bub=%b fwd=%0d rw=%b sm=%b sc=%0d",
                             n, a.st, a.h, a.pc, a.ie, a.bub, a.fw, a.rw, a.sm, a.sc,
                             e.st, e.h, e.pc, e.ie, e.bub, e.fw, e.rw, e.sm, e.sc);
                end
            end
        end
    end

    initial begin
        Reset                      = 1'b0;
        bus.Instruction_Code       = 8'h11;
        bus.IF_ID_Instruction_Code = 8'h80;
        bus.Resume                 = 1'b0;

        // Reset: free-running controls, decode live, even with HALT in ID
        step("rst_state",      8'h11, 8'h80, 0, 0, 1, mk(0,0,1,1,0,0,1,0,0));
        step("rst_halt_in_id", 8'h11, 8'hC0, 0, 0, 1, mk(0,0,1,1,0,0,1,0,0));

        // MOV then NOP, no hazards
        step("mov_if",     8'h11, 8'h80, 0, 1, 1, mk(0,0,1,1,0,0,1,0,0));
        step("nop_if",     8'h80, 8'h11, 0, 1, 1, mk(0,0,1,1,0,0,0,0,0));
        step("flush1",     8'h80, 8'h80, 0, 1, 1, mk(0,0,1,1,0,0,0,0,0));
        step("flush2",     8'h80, 8'h80, 0, 1, 1, mk(0,0,1,1,0,0,0,0,0));

        // SMOV r1 then dependent MOV r0<-r1 directly behind it
        step("smov_id",    8'h01, 8'h48, 0, 1, 1, mk(0,0,1,1,0,0,1,0,0));
        step("raw_ex",     8'h80, 8'h01, 0, 1, 1, mk(0,0,SP,SP,SB,F1,0,0,s(0)));
        step("raw_wb",     8'h80, 8'h01, 0, 1, 1, mk(0,0,SP,SP,SB,F2,0,0,s(1)));
        step("raw_clear",  8'h80, 8'h01, 0, 1, 1, mk(0,0,1,1,0,0,0,0,s(2)));
        step("gap_a",      8'h80, 8'h80, 0, 1, 1, mk(0,0,1,1,0,0,0,0,s(2)));
        step("gap_b",      8'h80, 8'h80, 0, 1, 1, mk(0,0,1,1,0,0,0,0,s(2)));

        // SMOV r1, NOP, MOV r0<-r1: WB-only match
        step("smov_b",     8'h48, 8'h48, 0, 1, 1, mk(0,0,1,1,0,0,1,1,s(2)));
        step("nop_gap",    8'h80, 8'h80, 0, 1, 1, mk(0,0,1,1,0,0,0,0,s(2)));
        step("raw_wb_only",8'h80, 8'h01, 0, 1, 1, mk(0,0,SP,SP,SB,F2,0,0,s(2)));
        step("raw_done",   8'h80, 8'h01, 0, 1, 1, mk(0,0,1,1,0,0,0,0,s(3)));
        step("gap_c",      8'h80, 8'h80, 0, 1, 1, mk(0,0,1,1,0,0,0,0,s(3)));
        step("gap_d",      8'h80, 8'h80, 0, 1, 1, mk(0,0,1,1,0,0,0,0,s(3)));

        // SMOV then HALT: 2 DRAIN cycles, HALTED, Resume, RESTART, RUN
        step("pre_halt",      8'h80, 8'h48, 0, 1, 1, mk(0,0,1,1,0,0,0,0,s(3)));
        step("halt_id",       8'h11, 8'hC0, 0, 1, 1, mk(0,0,0,0,1,0,1,0,s(3)));
        step("drain1_resume", 8'h11, 8'hC0, 1, 1, 1, mk(1,0,0,0,1,0,0,0,s(3)));
        step("drain2",        8'h80, 8'hC0, 0, 1, 1, mk(1,0,0,0,1,0,0,0,s(3)));
        step("halted",        8'h80, 8'hC0, 0, 1, 1, mk(2,1,0,0,1,0,0,0,s(3)));
        step("halted_resume", 8'h80, 8'hC0, 1, 1, 1, mk(2,1,0,0,1,0,0,0,s(3)));
        step("restart",       8'h80, 8'hC0, 0, 1, 1, mk(3,0,1,1,1,0,0,0,s(3)));
        step("run_resume",    8'h11, 8'h80, 1, 1, 1, mk(0,0,1,1,0,0,1,0,s(3)));
        step("run_after",     8'h80, 8'h80, 0, 1, 1, mk(0,0,1,1,0,0,0,0,s(3)));

        // 130 dependent SMOV/MOV pairs drive the counter into saturation
        for (int i = 0; i < 130; i++) begin
            step("pair_smov", 8'h80, 8'h48, 0, 1, 0, '0);
            step("pair_mov",  8'h80, 8'h01, 0, 1, 0, '0);
            step("pair_mov",  8'h80, 8'h01, 0, 1, 0, '0);
            step("pair_mov",  8'h80, 8'h01, 0, 1, 0, '0);
        end
        step("sat_gap",    8'h80, 8'h80, 0, 1, 1, mk(0,0,1,1,0,0,0,0,s(255)));
        step("sat_smov",   8'h80, 8'h48, 0, 1, 1, mk(0,0,1,1,0,0,0,0,s(255)));
        step("sat_raw_ex", 8'h80, 8'h01, 0, 1, 1, mk(0,0,SP,SP,SB,F1,0,0,s(255)));
        step("sat_raw_wb", 8'h80, 8'h01, 0, 1, 1, mk(0,0,SP,SP,SB,F2,0,0,s(255)));
        step("sat_hold",   8'h80, 8'h01, 0, 1, 1, mk(0,0,1,1,0,0,0,0,s(255)));

        // Halt again, then reset while HALTED with Resume pending
        step("halt2",          8'h80, 8'hC0, 0, 1, 1, mk(0,0,0,0,1,0,0,0,s(255)));
        step("halt2_drain1",   8'h80, 8'hC0, 0, 1, 1, mk(1,0,0,0,1,0,0,0,s(255)));
        step("halt2_drain2",   8'h80, 8'hC0, 0, 1, 1, mk(1,0,0,0,1,0,0,0,s(255)));
        step("halt2_halted",   8'h80, 8'hC0, 0, 1, 1, mk(2,1,0,0,1,0,0,0,s(255)));
        step("reset_halted",   8'h48, 8'hC0, 1, 0, 1, mk(0,0,1,1,0,0,1,1,0));
        step("post_reset_res", 8'h80, 8'h80, 1, 1, 1, mk(0,0,1,1,0,0,0,0,0));
        step("post_reset",     8'h80, 8'h80, 0, 1, 1, mk(0,0,1,1,0,0,0,0,0));

        // Let the monitor drain the queue, bounded
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(negedge Clk);
        end
        #1;
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: Clk and Reset.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- Clk  in  1  rising-edge clock
- Reset  in  1  async active-low reset
- Instruction_Code  in  8  IF-stage fetched instruction
- IF_ID_Instruction_Code  in  8  ID-stage instruction from the IF/ID register
- Resume  in  1  single-cycle restart request
- RegWrite  out  1  decoded write control for the IF/ID register
- SMCtrl  out  1  decoded immediate-select control for the IF/ID register
- PC_En  out  1  PC advance enable
- IF_ID_En  out  1  IF/ID load enable
- Bubble  out  1  inject NOP into ID/EX this cycle
- Fwd_Src  out  2  operand source: 00 regfile, 01 EX, 10 WB
- Halted  out  1  core halted
- State  out  2  FSM state encoding
- Stall_Count  out  8  saturating count of stall cycles
REQ-003 Instruction format SHALL be [7:6] opcode, [5:3] rd, [2:0] rs. Opcodes: 00 MOV rd<-rs; 01 SMOV rd<-imm3; 10 NOP; 11 HALT.

Function
REQ-004 RegWrite SHALL be 1 for opcodes 00 and 01 of Instruction_Code, and 0 otherwise; SMCtrl SHALL be 1 only for opcode 01. Both SHALL be forced to 0 when State is not RUN.
REQ-005 The block SHALL track writers with internal EX_v/EX_rd and WB_v/WB_rd registers. Each edge: WB <= EX; EX <= the ID writer (opcode 00/01, rd), or invalid when Bubble=1.
REQ-006 A RAW hazard SHALL exist when the ID opcode is 00 and rs equals EX_rd with EX_v=1, or rs equals WB_rd with WB_v=1.
REQ-007 FSM states SHALL be RUN=00, DRAIN=01, HALTED=10, RESTART=11.
REQ-008 In RUN with no hazard and no HALT in ID: PC_En=1, IF_ID_En=1, Bubble=0.
REQ-009 In RUN with an ID opcode of 11: next state DRAIN; PC_En=0, IF_ID_En=0, Bubble=1 in the same cycle.
REQ-010 In DRAIN: PC_En=0, IF_ID_En=0, Bubble=1. Once EX_v=0 and WB_v=0, next state is HALTED (at most 2 cycles).
REQ-011 In HALTED: Halted=1, PC_En=0, IF_ID_En=0, Bubble=1. Resume=1 moves to RESTART. Resume SHALL be ignored in every other state.
REQ-012 RESTART SHALL last exactly one cycle, with PC_En=1, IF_ID_En=1, Bubble=1 (the HALT is discarded), then go to RUN.
REQ-013 Stall_Count SHALL increment on every cycle a RAW stall is asserted, and saturate at 255.
REQ-014 HALT never reads a register, so it SHALL never raise a hazard. A hazard and a HALT cannot coincide.
REQ-015 All outputs other than State, Halted and Stall_Count SHALL be combinational from the current state, the trackers and the inputs.

Reset
REQ-016 Reset=0 SHALL asynchronously set: State=RUN; EX_v=WB_v=0; EX_rd=WB_rd=0; Stall_Count=0; Halted=0.
REQ-017 With Reset=0, outputs SHALL be PC_En=1, IF_ID_En=1, Bubble=0, Fwd_Src=00, RegWrite/SMCtrl per decode.
REQ-018 Reset asserted mid-DRAIN or mid-HALTED SHALL return the block to RUN with empty trackers. No pending Resume is retained.

Configuration
REQ-019 Macro FWD_EN: when defined, a RAW hazard SHALL NOT stall the pipeline. Fwd_Src SHALL be 01 on an EX match (EX has priority), 10 on a WB-only match, and 00 otherwise. Stall_Count SHALL stay 0.
REQ-020 When FWD_EN is undefined: Fwd_Src SHALL be constant 00. A RAW hazard in RUN SHALL force PC_En=0, IF_ID_En=0, Bubble=1 until the matching writer retires.

Verification
REQ-021 Reset, then feed 8'h11 followed by 8'h80 (NOP) -> RegWrite=1/SMCtrl=0 for 8'h11, then RegWrite=0 for 8'h80; no stalls; Stall_Count=0.
REQ-022 Without FWD_EN: 8'h48 (SMOV r1) with 8'h01 (MOV r0<-r1) directly behind it -> 2 stall cycles (PC_En=0, Bubble=1); Stall_Count=2.
REQ-023 With FWD_EN: the same sequence -> zero stalls; Fwd_Src=01 on the first ID cycle of 8'h01.
REQ-024 With FWD_EN: 8'h48, 8'h80, 8'h01 -> Fwd_Src=10 when 8'h01 is in ID.
REQ-025 8'h48 then 8'hC0 (HALT) -> DRAIN for 2 cycles, then HALTED with Halted=1. Resume pulse -> RESTART for one cycle (Bubble=1), then RUN. A Resume issued in RUN has no effect.
REQ-026 Without FWD_EN: 130 back-to-back dependent MOV pairs -> Stall_Count holds at 255. Reset asserted while HALTED -> State=00, Halted=0 immediately.
